// File: rtl/beat_meter_pkg.sv
// Shared definitions for the beat meter: FSM state encoding, default debounce
// and timeout limits, and the depth of the optional averaging window.
package beat_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_MIN_PERIOD = 16;
  localparam int unsigned DEFAULT_MAX_PERIOD = 65535;

  // Averaging window: 4 intervals, mean by right shift of 2.
  localparam int unsigned AVG_DEPTH = 4;
  localparam int unsigned AVG_SHIFT = 2;

endpackage : beat_meter_pkg

// File: rtl/beat_meter_sat_counter.sv
// sat_counter: interval counter with enable, synchronous load and saturation.
// Ports:
//   clk_i       - clock
//   rst_ni      - asynchronous active-low reset, clears the count
//   en_i        - increment by one when high (unless saturated)
//   load_i      - synchronous load, has priority over en_i
//   load_val_i  - value loaded when load_i is high
//   cnt_o       - current count
module sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LIMIT = 65535
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load wins over increment; increment stops at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q < WIDTH'(LIMIT))) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/beat_meter.sv
// beat_meter: measures the interval between beat pulses in count_en strobes.
// Beats closer than MIN_PERIOD strobes to the previous accepted beat are
// ignored; an interval reaching MAX_PERIOD abandons the measurement.
// Optional feature macro: BEAT_METER_AVG_EN -- report the mean of the last
// 4 accepted intervals instead of the latest raw interval.
// Ports:
//   clk          - clock, all state on rising edge
//   reset        - asynchronous active-low reset
//   count_en     - time-base strobe
//   beat_in      - one-cycle beat pulse
//   period       - latest (or averaged) interval, registered
//   period_valid - period holds a current measurement
//   new_period   - one-cycle pulse when period updates
//   timeout      - one-cycle pulse when a measurement is abandoned
module beat_meter
  import beat_meter_pkg::*;
#(
  parameter int unsigned SIGNAL_WIDTH = 16,
  parameter int unsigned MIN_PERIOD   = DEFAULT_MIN_PERIOD,
  parameter int unsigned MAX_PERIOD   = DEFAULT_MAX_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    count_en,
  input  logic                    beat_in,
  output logic [SIGNAL_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    new_period,
  output logic                    timeout
);

  localparam int unsigned SW = SIGNAL_WIDTH;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt;
  logic            cnt_inc;
  logic            cnt_load;
  logic [SW-1:0]   cnt_load_val;

  logic [SW-1:0]   period_q, period_d;
  logic            valid_q, valid_d;
  logic            new_q, new_d;
  logic            tmo_q, tmo_d;

  logic            active_c;
  logic            hit_max_c;
  logic            accept_c;

`ifdef BEAT_METER_AVG_EN
  localparam int unsigned ACC_W  = SW + 2;
  localparam int unsigned NACC_W = 3;

  logic [SW-1:0]     hist_q [AVG_DEPTH];
  logic [SW-1:0]     hist_d [AVG_DEPTH];
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic [NACC_W-1:0] nacc_q, nacc_d;
`endif

  // Interval counter
  sat_counter #(
    .WIDTH (SW),
    .LIMIT (MAX_PERIOD)
  ) u_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .en_i       (cnt_inc),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .cnt_o      (cnt)
  );

  // Timeout takes precedence over a coincident beat.
  assign active_c  = (state_q != IDLE);
  assign hit_max_c = active_c && (cnt == SW'(MAX_PERIOD));
  assign accept_c  = active_c && beat_in && !hit_max_c &&
                     (cnt >= SW'(MIN_PERIOD)) && (cnt < SW'(MAX_PERIOD));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (beat_in) state_d = ARMED;
      end
      ARMED, LOCKED: begin
        if (hit_max_c)     state_d = IDLE;
        else if (accept_c) state_d = LOCKED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control logic
  always_comb begin
    cnt_inc      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    period_d     = period_q;
    valid_d      = valid_q;
    new_d        = 1'b0;
    tmo_d        = 1'b0;
`ifdef BEAT_METER_AVG_EN
    hist_d       = hist_q;
    sum_d        = sum_q;
    nacc_d       = nacc_q;
`endif
    case (state_q)
      ARMED, LOCKED: begin
        if (hit_max_c) begin
          cnt_load = 1'b1;
          valid_d  = 1'b0;
          tmo_d    = 1'b1;
`ifdef BEAT_METER_AVG_EN
          for (int unsigned i = 0; i < AVG_DEPTH; i++) hist_d[i] = '0;
          sum_d  = '0;
          nacc_d = '0;
`endif
        end else if (accept_c) begin
          // A strobe coincident with the beat starts the next interval.
          cnt_load     = 1'b1;
          cnt_load_val = SW'(count_en);
`ifdef BEAT_METER_AVG_EN
          sum_d     = sum_q - ACC_W'(hist_q[AVG_DEPTH-1]) + ACC_W'(cnt);
          hist_d[0] = cnt;
          for (int unsigned i = 1; i < AVG_DEPTH; i++) hist_d[i] = hist_q[i-1];
          nacc_d = (nacc_q == NACC_W'(AVG_DEPTH)) ? nacc_q : nacc_q + NACC_W'(1);
          if (nacc_d == NACC_W'(AVG_DEPTH)) begin
            period_d = SW'(sum_d >> AVG_SHIFT);
            valid_d  = 1'b1;
            new_d    = 1'b1;
          end
`else
          period_d = cnt;
          valid_d  = 1'b1;
          new_d    = 1'b1;
`endif
        end else begin
          cnt_inc = count_en;
        end
      end
      default: begin
        // IDLE: counter held at zero until a beat arms it.
        cnt_load     = 1'b1;
        cnt_load_val = beat_in ? SW'(count_en) : '0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q <= '0;
      valid_q  <= 1'b0;
      new_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      valid_q  <= valid_d;
      new_q    <= new_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef BEAT_METER_AVG_EN
  // Averaging history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
      sum_q  <= '0;
      nacc_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      nacc_q <= nacc_d;
    end
  end
`endif

  assign period       = period_q;
  assign period_valid = valid_q;
  assign new_period   = new_q;
  assign timeout      = tmo_q;

endmodule : beat_meter

// File: doc/beat_meter.md
BEAT_METER -- requirements
Module: beat_meter

Interface
REQ-001 SHALL have parameter SIGNAL_WIDTH, default 16: width of the interval counter and period output.
REQ-002 SHALL have parameter MIN_PERIOD, default 16: beats arriving fewer than this many count_en strobes after the previous accepted beat are rejected (debounce).
REQ-003 SHALL have parameter MAX_PERIOD, default 65535: strobe count at which measurement times out; must satisfy MIN_PERIOD < MAX_PERIOD <= 2^SIGNAL_WIDTH-1.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port count_en, input, 1: time-base strobe; interval counter advances only on cycles where it is high.
REQ-007 SHALL have port beat_in, input, 1: beat pulse, one cycle high per beat.
REQ-008 SHALL have port period, output, SIGNAL_WIDTH: most recent measured beat interval, in count_en strobes.
REQ-009 SHALL have port period_valid, output, 1: high while period holds a current measurement.
REQ-010 SHALL have port new_period, output, 1: one-cycle pulse when period is updated.
REQ-011 SHALL have port timeout, output, 1: one-cycle pulse when the measurement is abandoned.

Function
REQ-012 SHALL implement states IDLE, ARMED, LOCKED.
REQ-013 IDLE: interval counter held at 0; beat_in -> ARMED, counter loads count_en ? 1 : 0.
REQ-014 ARMED/LOCKED: counter increments by 1 on each count_en, saturating at MAX_PERIOD.
REQ-015 In ARMED/LOCKED, beat_in with counter < MIN_PERIOD SHALL be ignored (no state, counter or output change).
REQ-016 In ARMED/LOCKED, beat_in with MIN_PERIOD <= counter < MAX_PERIOD SHALL be accepted: captured value = counter before that cycle's increment; counter loads count_en ? 1 : 0; state -> LOCKED.
REQ-017 On acceptance, period, period_valid=1 and new_period=1 SHALL appear on the cycle after beat_in (latency 1); new_period low on all other cycles.
REQ-018 Counter reaching MAX_PERIOD in ARMED/LOCKED SHALL, on the next cycle: state -> IDLE, counter -> 0, period_valid -> 0, timeout=1 for one cycle; period holds its last value.
REQ-019 beat_in on the same cycle the counter reaches MAX_PERIOD SHALL be treated as timeout; the beat is discarded.
REQ-020 Each count_en strobe SHALL be attributed to exactly one interval, including when coincident with an accepted beat.
REQ-021 period_valid SHALL stay high in LOCKED across accepted and rejected beats until timeout or reset.

Reset
REQ-022 reset low SHALL immediately force state IDLE, counter 0, period 0, period_valid 0, new_period 0, timeout 0, averaging history cleared.
REQ-023 Reset mid-measurement SHALL discard the partial interval; first beat after release only arms.

Configuration
REQ-024 With BEAT_METER_AVG_EN defined, period SHALL be the mean (sum of last 4 accepted intervals, truncated right-shift by 2, SIGNAL_WIDTH+2-bit accumulator) and period_valid SHALL rise only after 4 intervals accepted since IDLE; timeout clears history.
REQ-025 Without BEAT_METER_AVG_EN, period SHALL be the latest raw interval and period_valid SHALL rise on the first accepted interval; no averaging logic synthesized.

Structure
REQ-026 State encodings and default MIN_PERIOD/MAX_PERIOD constants SHALL live in the shared music-synth package/header.
REQ-027 The interval counter SHALL be a sub-module sat_counter (enable, synchronous load, saturate-at-limit, async active-low reset); state registers SHALL use the team's existing flop primitives.

Verification
REQ-028 count_en=1 every cycle, beat_in every 100 cycles -> after 2nd beat: period=100, period_valid=1, new_period one cycle each beat.
REQ-029 Extra beat 5 strobes after an accepted beat (MIN_PERIOD=16) -> ignored; next beat at +100 gives period=100.
REQ-030 MAX_PERIOD=200, single beat then no beats -> timeout pulse exactly once, period_valid=0, state IDLE; next beat only arms.
REQ-031 count_en every 4th cycle, beats 480 cycles apart, beat coincident with count_en -> period=120 every interval, no strobe lost or double-counted.
REQ-032 reset low mid-interval for 1 cycle -> all outputs 0 immediately; measurement restarts from IDLE.
REQ-033 BEAT_METER_AVG_EN defined, intervals 100,104,96,100 -> period_valid rises on 4th, period=100; without macro, period tracks each raw value.
